// File: rtl/tm_pkg.sv
// tm_pkg
//  Shared definitions for the lab3 Turing-machine controller: FSM state
//  encoding, head-move codes, fault codes and the bit layout of one rule
//  entry. A rule entry is {halt, next_state, move[1:0], write_sym}, with
//  write_sym in the low bits. The field offsets depend on the symbol and
//  state widths, so they are provided as constant functions of those widths.
package tm_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_EXEC,
    ST_DONE,
    ST_FAULT
  } tm_state_e;

  localparam int          HEAD_W     = 3;
  localparam logic [2:0]  HEAD_MAX   = 3'd7;

  localparam logic [1:0]  MOVE_STAY  = 2'b00;
  localparam logic [1:0]  MOVE_LEFT  = 2'b01;
  localparam logic [1:0]  MOVE_RIGHT = 2'b10;

  localparam logic [1:0]  FAULT_NONE     = 2'b00;
  localparam logic [1:0]  FAULT_BOUNDARY = 2'b01;
  localparam logic [1:0]  FAULT_TIMEOUT  = 2'b10;

  localparam int WSYM_LSB = 0;

  function automatic int move_lsb(input int size);
    return size;
  endfunction

  function automatic int next_lsb(input int size);
    return size + 2;
  endfunction

  function automatic int halt_bit(input int size, input int state_w);
    return size + 2 + state_w;
  endfunction

  function automatic int rule_width(input int size, input int state_w);
    return 1 + state_w + 2 + size;
  endfunction

endpackage

// File: rtl/tm_if.sv
// tm_if
//  Tape bus between the controller and the 8-cell tape.
//  head        3     cell addressed by the controller
//  write_ena   1     write strobe, tape writes on the rising clock edge
//  write_data  SIZE  symbol to write
//  read_data   SIZE  symbol currently under the head
//  master = controller side, slave = tape side.
interface tm_if #(
  parameter int SIZE = 2
);

  logic [2:0]      head;
  logic            write_ena;
  logic [SIZE-1:0] write_data;
  logic [SIZE-1:0] read_data;

  modport master (
    output head,
    output write_ena,
    output write_data,
    input  read_data
  );

  modport slave (
    input  head,
    input  write_ena,
    input  write_data,
    output read_data
  );

endinterface

// File: rtl/tm_rule_table.sv
// tm_rule_table
//  Programmable rule store of the Turing machine, one entry per
//  {state, symbol} pair. Synchronous write, synchronous clear on rst
//  (a cleared entry means: write 0, stay, next state 0, no halt),
//  combinational read.
//  clk, rst   clock and synchronous active-high reset
//  we         write strobe (already qualified by the controller)
//  waddr      entry written when we=1
//  wdata      entry contents
//  raddr      entry looked up
//  rdata      contents of entry raddr
module tm_rule_table #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];

  always_comb begin
    mem_d = mem_q;
    if (we) begin
      mem_d[waddr] = wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q <= '{default: '0};
    end else begin
      mem_q <= mem_d;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/tm_controller.sv
// tm_controller
//  Finite-state control unit of the lab3 Turing machine. Each step takes two
//  cycles: FETCH latches the rule for {cur_state, symbol under head}, EXEC
//  writes the rule's symbol to the tape, moves the head and advances the
//  state. A run ends on a halt rule (done), a move off either tape end
//  (fault code 01) or after MAX_STEPS steps (fault code 10).
//  clk, rst     clock and synchronous active-high reset
//  start        one-cycle pulse starting a run (accepted when not busy)
//  start_head   initial head position, sampled with an accepted start
//  rule_we      rule write strobe (accepted when not busy)
//  rule_addr    {state, symbol} of the rule written
//  rule_wdata   {halt, next_state, move[1:0], write_sym}
//  tape         tape bus (head, write_ena, write_data out; read_data in)
//  busy         run in progress
//  done/fault   run ended normally / abnormally, held until next start
//  fault_code   01 boundary, 10 timeout, 00 none
//  cur_state    current machine state
//  steps        completed steps of the current or last run
module tm_controller
  import tm_pkg::*;
#(
  parameter int SIZE      = 2,
  parameter int STATE_W   = 2,
  parameter int STEP_W    = 8,
  parameter int MAX_STEPS = 200
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [2:0]              start_head,
  input  logic                    rule_we,
  input  logic [STATE_W+SIZE-1:0] rule_addr,
  input  logic [STATE_W+SIZE+2:0] rule_wdata,
  tm_if.master                    tape,
  output logic                    busy,
  output logic                    done,
  output logic                    fault,
  output logic [1:0]              fault_code,
  output logic [STATE_W-1:0]      cur_state,
  output logic [STEP_W-1:0]       steps
);

  localparam int ADDR_W   = STATE_W + SIZE;
  localparam int RULE_W   = rule_width(SIZE, STATE_W);
  localparam int MOVE_LSB = move_lsb(SIZE);
  localparam int NEXT_LSB = next_lsb(SIZE);
  localparam int HALT_BIT = halt_bit(SIZE, STATE_W);

  tm_state_e           state_q, state_d;
  logic [HEAD_W-1:0]   head_q, head_d;
  logic [STATE_W-1:0]  cur_state_q, cur_state_d;
  logic [STEP_W-1:0]   steps_q, steps_d;
  logic [1:0]          fault_code_q, fault_code_d;
  logic [RULE_W-1:0]   rule_q, rule_d;

  logic                accepting;
  logic [RULE_W-1:0]   table_rdata;
  logic [SIZE-1:0]     r_wsym;
  logic [1:0]          r_move;
  logic [STATE_W-1:0]  r_next;
  logic                r_halt;
  logic [HEAD_W-1:0]   moved_head;
  logic                at_boundary;
  logic [STEP_W-1:0]   steps_inc;

  // start and rule writes are only honoured outside a run
  assign accepting = (state_q == ST_IDLE) || (state_q == ST_DONE) || (state_q == ST_FAULT);

  tm_rule_table #(
    .ADDR_W (ADDR_W),
    .DATA_W (RULE_W)
  ) u_rule_table (
    .clk   (clk),
    .rst   (rst),
    .we    (rule_we && accepting),
    .waddr (rule_addr),
    .wdata (rule_wdata),
    .raddr ({cur_state_q, tape.read_data}),
    .rdata (table_rdata)
  );

  assign r_wsym = rule_q[WSYM_LSB +: SIZE];
  assign r_move = rule_q[MOVE_LSB +: 2];
  assign r_next = rule_q[NEXT_LSB +: STATE_W];
  assign r_halt = rule_q[HALT_BIT];

  assign steps_inc = steps_q + 1'b1;

  // Candidate head position for the latched rule, and whether that move
  // would leave the tape (the head never wraps)
  always_comb begin
    moved_head  = head_q;
    at_boundary = 1'b0;
    case (r_move)
      MOVE_LEFT: begin
        moved_head  = head_q - 3'd1;
        at_boundary = (head_q == '0);
      end
      MOVE_RIGHT: begin
        moved_head  = head_q + 3'd1;
        at_boundary = (head_q == HEAD_MAX);
      end
      default: begin
        moved_head  = head_q;
        at_boundary = 1'b0;
      end
    endcase
  end

  // Next-state logic; EXEC exits are prioritised boundary > halt > timeout
  always_comb begin
    state_d      = state_q;
    head_d       = head_q;
    cur_state_d  = cur_state_q;
    steps_d      = steps_q;
    fault_code_d = fault_code_q;
    rule_d       = rule_q;
    case (state_q)
      ST_IDLE, ST_DONE, ST_FAULT: begin
        if (start) begin
          head_d       = start_head;
          cur_state_d  = '0;
          steps_d      = '0;
          fault_code_d = FAULT_NONE;
          state_d      = ST_FETCH;
        end
      end
      ST_FETCH: begin
        rule_d  = table_rdata;
        state_d = ST_EXEC;
      end
      ST_EXEC: begin
        steps_d     = steps_inc;
        cur_state_d = r_next;
        if (at_boundary) begin
          fault_code_d = FAULT_BOUNDARY;
          state_d      = ST_FAULT;
        end else if (r_halt) begin
          head_d  = moved_head;
          state_d = ST_DONE;
        end else if (steps_inc == STEP_W'(MAX_STEPS)) begin
          head_d       = moved_head;
          fault_code_d = FAULT_TIMEOUT;
          state_d      = ST_FAULT;
        end else begin
          head_d  = moved_head;
          state_d = ST_FETCH;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      head_q       <= '0;
      cur_state_q  <= '0;
      steps_q      <= '0;
      fault_code_q <= FAULT_NONE;
      rule_q       <= '0;
    end else begin
      state_q      <= state_d;
      head_q       <= head_d;
      cur_state_q  <= cur_state_d;
      steps_q      <= steps_d;
      fault_code_q <= fault_code_d;
      rule_q       <= rule_d;
    end
  end

  // rst masks the EXEC write so an aborted step leaves the tape untouched
  assign tape.write_ena  = (state_q == ST_EXEC) && !rst;
  assign tape.write_data = tape.write_ena ? r_wsym : '0;
  assign tape.head       = head_q;

  assign busy       = (state_q == ST_FETCH) || (state_q == ST_EXEC);
  assign done       = (state_q == ST_DONE);
  assign fault      = (state_q == ST_FAULT);
  assign fault_code = fault_code_q;
  assign cur_state  = cur_state_q;
  assign steps      = steps_q;

endmodule
